// File: rtl/loader_pkg.sv
// Shared types and widths for the instruction-memory boot loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

  localparam int HDR_W  = 16;
  localparam int CSUM_W = 8;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word packer; word_valid marks the byte that completes a word.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        valid,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] shift;
  logic [1:0]  idx;

  // The completing byte is presented directly so the caller can register it in the same edge.
  assign word       = {in_byte, shift};
  assign word_valid = valid && (idx == 2'd3);

  // Shift earlier bytes down so byte 0 ends up in bits [7:0].
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      shift <= '0;
      idx   <= '0;
    end else if (valid) begin
      shift <= {in_byte, shift[23:8]};
      idx   <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes instruction words,
// verifies the XOR checksum and releases the CPU reset only after a good load.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// HDR_LO | expecting N[7:0]
// HDR_HI | expecting N[15:8]; length is range-checked here
// DATA   | receiving 4*N instruction bytes
// CSUM   | expecting the checksum byte
// DONE   | load good, CPU released
// ERROR  | overflow or checksum mismatch, CPU held
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state, nxt;
  logic [7:0]        n_lo;
  logic [HDR_W-1:0]  n_words;
  logic [HDR_W-1:0]  hdr;
  logic [ADDR_W:0]   wcnt;
  logic [CSUM_W-1:0] csum;
  logic              xfer;
  logic              can_start;
  logic              last_word;
  logic [31:0]       word;
  logic              word_valid;

  assign xfer      = in_valid && in_ready;
  assign can_start = start && (state == IDLE || state == DONE || state == ERROR);
  assign hdr       = {in_data, n_lo};
  assign last_word = (32'(wcnt) + 32'd1) == 32'(n_words);

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (can_start),
    .valid     (xfer && state == DATA),
    .in_byte   (in_data),
    .word      (word),
    .word_valid(word_valid)
  );

  // Next-state selection from current state and the byte handshake.
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERROR: if (start) nxt = HDR_LO;
      HDR_LO:            if (xfer) nxt = HDR_HI;
      HDR_HI: begin
        if (xfer) begin
          if (hdr == '0)                             nxt = CSUM;
          else if (32'(hdr) > (32'd1 << ADDR_W))     nxt = ERROR;
          else                                       nxt = DATA;
        end
      end
      DATA:   if (word_valid && last_word) nxt = CSUM;
      CSUM:   if (xfer) nxt = (in_data == csum) ? DONE : ERROR;
      default: nxt = IDLE;
    endcase
  end

  // State register with status outputs decoded from the next state so they are registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_rst  <= 1'b1;
    end else begin
      state    <= nxt;
      in_ready <= (nxt == HDR_LO || nxt == HDR_HI || nxt == DATA || nxt == CSUM);
      busy     <= (nxt == HDR_LO || nxt == HDR_HI || nxt == DATA || nxt == CSUM);
      done     <= (nxt == DONE);
      err      <= (nxt == ERROR);
      cpu_rst  <= (nxt != DONE);
    end
  end

  // Header capture, checksum accumulation, word counter and write-port registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      n_lo       <= '0;
      n_words    <= '0;
      wcnt       <= '0;
      csum       <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= word_valid;
      if (word_valid) begin
        imem_waddr <= wcnt[ADDR_W-1:0];
        imem_wdata <= word;
        wcnt       <= wcnt + 1'b1;
      end
      if (xfer && state == HDR_LO) n_lo    <= in_data;
      if (xfer && state == HDR_HI) n_words <= hdr;
      if (xfer && state == DATA)   csum    <= csum ^ in_data;
      if (can_start) begin
        wcnt <= '0;
        csum <= '0;
      end
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of `r_cpu`. It accepts a byte stream over a valid/ready interface, assembles little-endian 32-bit instruction words, writes them into the CPU instruction memory, and verifies a checksum. The CPU is held in reset (`cpu_rst` high) until a load completes with a matching checksum, so `r_cpu` always starts at PC 0 with a complete program.

## Interface
Parameters:
- `ADDR_W`, 8: instruction-memory word-address width; depth is 2^ADDR_W words.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_ready`  out  1  loader can accept a byte; a byte transfers when `in_valid && in_ready`.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_waddr`  out  ADDR_W  word address of the write.
- `imem_wdata`  out  32  instruction word.
- `cpu_rst`  out  1  active-high reset to `r_cpu`.
- `busy`  out  1  load in progress (HDR_LO..CSUM).
- `done`  out  1  last load succeeded.
- `err`  out  1  last load failed (length overflow or checksum mismatch).

## Operation
- Stream format: N[7:0], N[15:8], then 4·N instruction bytes (byte 0 is word bits [7:0]), then 1 checksum byte equal to the XOR of all instruction bytes. Header bytes are excluded from the checksum.
- States and transitions:
  - IDLE → HDR_LO on `start`.
  - HDR_LO → HDR_HI on a byte transfer.
  - HDR_HI → DATA on a byte transfer with 0 < N ≤ 2^ADDR_W.
  - HDR_HI → CSUM if N = 0.
  - HDR_HI → ERROR if N > 2^ADDR_W.
  - DATA → CSUM after the 4·N-th byte.
  - CSUM → DONE if the checksum byte matches the running XOR; otherwise CSUM → ERROR.
  - DONE or ERROR → HDR_LO on `start`.
- `in_ready` = 1 exactly in HDR_LO, HDR_HI, DATA and CSUM. It is decoded from state only and has no combinational path from `in_valid`.
- Word packing:
  - A 2-bit byte index and a word counter both reset on `start`.
  - The 4th byte of a word completes it. Word k is written to address k.
- `cpu_rst` = 1 in every state except DONE.
- `done` = 1 only in DONE; `err` = 1 only in ERROR.
- Words already written before an ERROR stay in memory. `cpu_rst` remains asserted.
- `start` while `busy` is ignored.
- Gaps (`in_valid` low) may occur anywhere; state and counters hold.

## Timing
- Reset values (cycle after `rst` sampled low): state IDLE, `cpu_rst`=1. All other outputs are 0: `in_ready`, `imem_we`, `imem_waddr`, `imem_wdata`, `busy`, `done`, `err`. Reset mid-load aborts immediately, and no further write strobes are issued.
- `start` sampled at edge t: `in_ready`=1 and `busy`=1 from t+1.
- Write latency:
  - `imem_we`, `imem_waddr` and `imem_wdata` are registered.
  - A strobe is high the cycle after the 4th byte of a word transfers and is never high two cycles running.
  - The last word's strobe coincides with the first CSUM cycle.
- Checksum byte transfers at edge t: `done`/`err` rise and `cpu_rst` falls at t+1. `in_ready` falls at t+1.
- Length overflow is detected at the HDR_HI transfer edge, and ERROR is entered the next cycle.
- `start` in DONE at edge t: `cpu_rst`=1 and `done`=0 at t+1.
- N is 16 bits and the word counter is ADDR_W+1 bits, so N = 2^ADDR_W is legal with no wrap.

## Structure
- Package `loader_pkg` contains:
  - the state enum (IDLE, HDR_LO, HDR_HI, DATA, CSUM, DONE, ERROR);
  - the header width constant (16);
  - the checksum width constant (8).
- Sub-module `byte_packer`:
  - ports: byte in, valid in, clear in, word out, word_valid out;
  - shifts bytes little-endian and pulses `word_valid` on the 4th byte.
- The top level holds the FSM, word counter, XOR accumulator and write-port registers.

## Test plan
- Load of 3 words:
  - Stimulus: `start`, then bytes 03 00 93 00 50 00 13 01 30 00 B3 81 20 00 F3.
  - Response: writes addr0=00500093, addr1=00300113, addr2=002081B3; `done`=1; `cpu_rst`=0; `err`=0.
- Same stream with checksum F2: identical 3 writes, then `err`=1, `cpu_rst`=1, `done`=0.
- Empty program:
  - Stimulus: bytes 00 00 00.
  - Response: no `imem_we`; `done`=1 one cycle after the 3rd byte.
- Length overflow (ADDR_W=8):
  - Stimulus: header 01 01 (N=257).
  - Response: ERROR, `in_ready`=0, no writes, `err`=1.
- Randomised backpressure:
  - Stimulus: 3-word stream with random `in_valid` gaps.
  - Response: same writes and order as the first test.
  - Stimulus: `rst` low after the 6th byte.
  - Response: IDLE next cycle, `cpu_rst`=1, no further writes.
- `start` handling:
  - Stimulus: `start` pulsed mid-DATA.
  - Response: ignored; byte index and counter unaffected.
  - Stimulus: `start` in DONE.
  - Response: `cpu_rst`=1 and `in_ready`=1 next cycle; a second load writes again from address 0.
